rssi_db_conv: RTL and testbench
===============================

RSSI_DB_CONV -- requirements
Module: rssi_db_conv

Interface
REQ-001 SHALL have parameter POW_WIDTH, default 26: width of the incoming window power word.
REQ-002 SHALL have parameter AVG_FRAC, default 4: number of fractional bits held in the averaging register.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_pow_vld, input, 1: one-cycle strobe marking a new 10 ms window power.
REQ-006 SHALL have port i_pow, input, POW_WIDTH: unsigned window power, sampled when i_pow_vld=1.
REQ-007 SHALL have port i_alpha_shift, input, 2: IIR smoothing shift k, 0..3.
REQ-008 SHALL have port i_thr_hi, input, 9: high threshold, 0.25 dB units.
REQ-009 SHALL have port i_thr_lo, input, 9: low threshold, 0.25 dB units.
REQ-010 SHALL have port o_vld, output, 1: one-cycle strobe marking updated outputs.
REQ-011 SHALL have port o_rssi_db, output, 9: instantaneous 10*log10(pow), unsigned, 0.25 dB units.
REQ-012 SHALL have port o_rssi_avg, output, 9: smoothed dB value, integer part of the averaging register.
REQ-013 SHALL have port o_zero, output, 1: last window power was 0.
REQ-014 SHALL have port o_high, output, 1: hysteresis level flag.
REQ-015 SHALL have port o_overrun, output, 1: sticky flag for a strobe dropped while busy.

Function
REQ-016 SHALL use FSM states IDLE, NORM, CALC and AVG.
- IDLE: on i_pow_vld, capture i_pow into x, clear shift count s, go to NORM.
- NORM: if x[POW_WIDTH-1]=1 or x=0, go to CALC; otherwise x<<=1 and s++, one bit per cycle.
- CALC: one cycle, then AVG.
- AVG: one cycle, then IDLE.
REQ-017 SHALL compute the exponent e=POW_WIDTH-1-s and the mantissa m=x[POW_WIDTH-2:POW_WIDTH-5] (4 bits below the leading one, zero-padded by the shift).
REQ-018 SHALL compute db_q8=e*3083+LUT[m] in CALC, where LUT[m]=round(10240*log10(1+m/16)): LUT[0]=0, LUT[15]=2941.
REQ-019 SHALL register o_rssi_db=(db_q8+128)>>8; for x=0 it SHALL register o_rssi_db=0 and o_zero=1, otherwise o_zero=0.
REQ-020 SHALL update the averaging register avg (9+AVG_FRAC bits, unsigned) in AVG as follows:
- first sample after reset: avg=db<<AVG_FRAC;
- afterwards: avg+=((db<<AVG_FRAC)-avg)>>>k, with the difference signed and the arithmetic shift;
- no overflow is possible.
REQ-021 SHALL drive o_rssi_avg=avg>>AVG_FRAC.
REQ-022 SHALL, in the same AVG cycle and evaluated on the new avg value, set o_high when o_rssi_avg>=i_thr_hi and clear it when o_rssi_avg<i_thr_lo; otherwise o_high holds.
REQ-023 SHALL give i_thr_hi priority when the hysteresis band is inverted (i_thr_lo>i_thr_hi).
REQ-024 SHALL register o_vld high for exactly one cycle, at cycle 4+s after the i_pow_vld cycle (s=0 when pow=0). Latency is 4..29 cycles.
REQ-025 SHALL set o_overrun when i_pow_vld is seen outside IDLE, drop that sample, and leave the FSM unaffected.
REQ-026 SHALL accept i_pow_vld again in the cycle o_vld is high, since the FSM is back in IDLE.
REQ-027 SHALL hold o_rssi_db, o_rssi_avg, o_zero and o_high stable between o_vld strobes.
REQ-028 SHALL sample i_alpha_shift and the thresholds only in the AVG state.

Reset
REQ-029 SHALL, on i_rst, force all of these asynchronously: FSM=IDLE, x=0, s=0, avg=0, first-sample flag set, and all outputs 0.
REQ-030 SHALL abandon any conversion in progress on reset mid-operation without producing o_vld.
REQ-031 SHALL clear o_overrun only by reset.

Structure
REQ-032 SHALL place the constants 3083, the 16-entry LUT, the state encoding and the 0.25 dB unit definition in a shared RSSI package.
REQ-033 SHALL implement the LUT as sub-module rssi_log_lut, a combinational 4-bit to 12-bit ROM.

Verification
REQ-034 SHALL cover: pow=1 -> o_rssi_db=0, o_zero=0, o_vld at cycle 29.
REQ-035 SHALL cover: pow=2^20 -> o_rssi_db=241, o_vld at cycle 9; pow=2^25 -> o_rssi_db=301, o_vld at cycle 4.
REQ-036 SHALL cover: pow=0 -> o_rssi_db=0, o_zero=1, o_vld at cycle 4.
REQ-037 SHALL cover, with k=1: first sample 241 -> avg 241; second sample 201 -> avg 221.
REQ-038 SHALL cover, with thr_hi=200 and thr_lo=180: averages 190, 205, 190, 175 -> o_high 0, 1, 1, 0.
REQ-039 SHALL cover: a second i_pow_vld 2 cycles after the first -> o_overrun=1 and exactly one o_vld; i_rst asserted during NORM -> no o_vld and all outputs 0.

Source files
------------

// File: rtl/rssi_pkg.sv
// Shared constants for the RSSI dB converter: log LUT, octave step,
// FSM encoding and the 0.25 dB output unit.
package rssi_pkg;

  // One octave (x2 in power) is 10*log10(2) dB = 12.04 quarter-dB; held here with 8 fraction bits.
  localparam int DB_Q8_PER_OCTAVE = 3083;
  localparam int DB_FRAC_BITS     = 8;

  // Output unit: one LSB is 0.25 dB, so 4 LSBs per dB.
  localparam int QDB_PER_DB = 4;
  typedef logic [8:0] qdb_t;

  // round(10240*log10(1+m/16)), indexed by the 4 mantissa bits below the leading one.
  localparam logic [15:0][11:0] LOG_LUT = {
    12'd2941, 12'd2796, 12'd2645, 12'd2489,
    12'd2327, 12'd2159, 12'd1985, 12'd1803,
    12'd1614, 12'd1416, 12'd1209, 12'd992,
    12'd764,  12'd524,  12'd270,  12'd0
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_CALC = 2'd2;
  localparam logic [1:0] ST_AVG  = 2'd3;

endpackage

// File: rtl/rssi_log_lut.sv
// Combinational fractional-log ROM: 4-bit mantissa to 12-bit q8 quarter-dB offset.
module rssi_log_lut
  import rssi_pkg::*;
(
  input  logic [3:0]  addr,
  output logic [11:0] data
);

  assign data = LOG_LUT[addr];

endmodule

// File: rtl/rssi_db_conv.sv
// Window power to dB converter: serial leading-one normalisation, log LUT,
// first-order IIR smoothing and a hysteresis level flag.
module rssi_db_conv
  import rssi_pkg::*;
#(
  parameter int POW_WIDTH = 26,
  parameter int AVG_FRAC  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pow_vld,
  input  logic [POW_WIDTH-1:0] i_pow,
  input  logic [1:0]           i_alpha_shift,
  input  logic [8:0]           i_thr_hi,
  input  logic [8:0]           i_thr_lo,
  output logic                 o_vld,
  output logic [8:0]           o_rssi_db,
  output logic [8:0]           o_rssi_avg,
  output logic                 o_zero,
  output logic                 o_high,
  output logic                 o_overrun
);

  localparam int SW = $clog2(POW_WIDTH);
  localparam int AW = 9 + AVG_FRAC;
  localparam int QW = $clog2(POW_WIDTH * DB_Q8_PER_OCTAVE + 4096);

  logic [1:0]           state;
  logic [POW_WIDTH-1:0] x;
  logic [SW-1:0]        s;
  qdb_t                 db;
  logic                 zero_q;
  logic [AW-1:0]        avg;
  logic                 first;

  logic [3:0]           mant;
  logic [11:0]          lut_val;
  logic [SW-1:0]        expo;
  logic [QW-1:0]        db_q8;
  qdb_t                 db_round;
  logic                 x_zero;

  logic [AW-1:0]        db_ext;
  logic signed [AW:0]   diff;
  logic signed [AW:0]   step;
  logic [AW-1:0]        avg_sum;
  logic [AW-1:0]        avg_next;
  logic [8:0]           avg_next_int;

  assign mant   = x[POW_WIDTH-2 -: 4];
  assign x_zero = (x == '0);

  rssi_log_lut u_lut (
    .addr (mant),
    .data (lut_val)
  );

  assign expo     = SW'(POW_WIDTH - 1) - s;
  assign db_q8    = QW'(expo) * QW'(DB_Q8_PER_OCTAVE) + QW'(lut_val);
  assign db_round = 9'((db_q8 + QW'(1 << (DB_FRAC_BITS - 1))) >> DB_FRAC_BITS);

  // The difference is signed; the arithmetic shift keeps decay toward lower values exact.
  assign db_ext       = {db, {AVG_FRAC{1'b0}}};
  assign diff         = $signed({1'b0, db_ext}) - $signed({1'b0, avg});
  assign step         = diff >>> i_alpha_shift;
  assign avg_sum      = avg + AW'(step);
  assign avg_next     = first ? db_ext : avg_sum;
  assign avg_next_int = avg_next[AW-1:AVG_FRAC];

  assign o_rssi_avg = avg[AW-1:AVG_FRAC];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      x         <= '0;
      s         <= '0;
      db        <= '0;
      zero_q    <= 1'b0;
      avg       <= '0;
      first     <= 1'b1;
      o_vld     <= 1'b0;
      o_rssi_db <= '0;
      o_zero    <= 1'b0;
      o_high    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      if (i_pow_vld && state != ST_IDLE) begin
        o_overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_pow_vld) begin
            x     <= i_pow;
            s     <= '0;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (x[POW_WIDTH-1] || x_zero) begin
            state <= ST_CALC;
          end else begin
            x <= x << 1;
            s <= s + 1'b1;
          end
        end
        ST_CALC: begin
          db     <= x_zero ? '0 : db_round;
          zero_q <= x_zero;
          state  <= ST_AVG;
        end
        ST_AVG: begin
          avg       <= avg_next;
          first     <= 1'b0;
          o_rssi_db <= db;
          o_zero    <= zero_q;
          o_vld     <= 1'b1;
          // High threshold wins when the band is inverted.
          if (avg_next_int >= i_thr_hi) begin
            o_high <= 1'b1;
          end else if (avg_next_int < i_thr_lo) begin
            o_high <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rssi_db_conv.sv
// Scoreboard bench for rssi_db_conv: a real-arithmetic dB/IIR model feeds a
// queue, a monitor pops and compares on every o_vld.
module tb_rssi_db_conv;

  logic        clk;
  logic        rst;
  logic        pow_vld;
  logic [25:0] pow;
  logic [1:0]  alpha_shift;
  logic [8:0]  thr_hi;
  logic [8:0]  thr_lo;
  logic        vld;
  logic [8:0]  rssi_db;
  logic [8:0]  rssi_avg;
  logic        zero;
  logic        high;
  logic        overrun;

  rssi_db_conv #(.POW_WIDTH(26), .AVG_FRAC(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pow_vld     (pow_vld),
    .i_pow         (pow),
    .i_alpha_shift (alpha_shift),
    .i_thr_hi      (thr_hi),
    .i_thr_lo      (thr_lo),
    .o_vld         (vld),
    .o_rssi_db     (rssi_db),
    .o_rssi_avg    (rssi_avg),
    .o_zero        (zero),
    .o_high        (high),
    .o_overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned pow;
    int db;
    int avg;
    int zero;
    int high;
    int cyc;
    int chk_db;
    int chk_avg;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;

  int avg_m = 0;
  int first_m = 1;
  int high_m = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // dB from the mathematical definition: exponent of the leading one,
  // next 4 bits as mantissa, LUT value computed from log10 directly.
  function automatic int model_db(input int unsigned p, output int s);
    int e, m, lut;
    if (p == 0) begin
      s = 0;
      return 0;
    end
    e = 0;
    for (int b = 0; b < 26; b++) if (p[b]) e = b;
    s = 25 - e;
    m = int'(((p << s) >> 21) & 15);
    lut = int'(10240.0 * $log10(1.0 + real'(m) / 16.0));
    return (e * 3083 + lut + 128) >>> 8;
  endfunction

  task automatic model_reset();
    avg_m = 0;
    first_m = 1;
    high_m = 0;
    sb.delete();
  endtask

  task automatic issue(input int unsigned p, input int k, input int hi, input int lo,
                       input int cdb, input int cavg);
    exp_t e;
    int s, db, a_int;
    db = model_db(p, s);
    if (first_m != 0) avg_m = db * 16;
    else avg_m = avg_m + ((db * 16 - avg_m) >>> k);
    first_m = 0;
    a_int = avg_m / 16;
    if (a_int >= hi) high_m = 1;
    else if (a_int < lo) high_m = 0;
    e.pow = p; e.db = db; e.avg = a_int; e.zero = (p == 0) ? 1 : 0;
    e.high = high_m; e.cyc = cyc + 4 + s; e.chk_db = cdb; e.chk_avg = cavg;
    sb.push_back(e);
    pow = p[25:0];
    alpha_shift = k[1:0];
    thr_hi = hi[8:0];
    thr_lo = lo[8:0];
    pow_vld = 1'b1;
    @(negedge clk);
    pow_vld = 1'b0;
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    while (vld !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (vld !== 1'b1) begin
      failures++;
      $display("FAIL vld_timeout actual=no_vld required=vld_within_40_cycles");
    end
  endtask

  task automatic send(input int unsigned p, input int k, input int hi, input int lo,
                      input int cdb, input int cavg);
    issue(p, k, hi, lo, cdb, cavg);
    wait_vld();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vld"}, int'(vld), 0);
    chk({tag, "_db"}, int'(rssi_db), 0);
    chk({tag, "_avg"}, int'(rssi_avg), 0);
    chk({tag, "_zero"}, int'(zero), 0);
    chk({tag, "_high"}, int'(high), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every o_vld must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vld === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_vld actual=vld required=none at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          txn++;
          $display("txn %0d pow=%0d db=%0d avg=%0d zero=%0d high=%0d cycle=%0d",
                   txn, e.pow, rssi_db, rssi_avg, zero, high, cyc);
          chk("rssi_db", int'(rssi_db), e.db);
          chk("rssi_avg", int'(rssi_avg), e.avg);
          chk("zero", int'(zero), e.zero);
          chk("high", int'(high), e.high);
          chk("latency_cycle", cyc, e.cyc);
          if (e.chk_db >= 0) chk("rssi_db_const", int'(rssi_db), e.chk_db);
          if (e.chk_avg >= 0) chk("rssi_avg_const", int'(rssi_avg), e.chk_avg);
        end
      end
    end
  end

  initial begin
    int unsigned p;
    rst = 1'b1;
    pow_vld = 1'b0;
    pow = '0;
    alpha_shift = 2'd0;
    thr_hi = 9'd511;
    thr_lo = 9'd0;
    @(negedge clk);
    do_reset();

    // First sample seeds the average, second is smoothed with k=1.
    send(32'd1 << 20, 1, 511, 0, 241, 241);
    send(32'd106496, 1, 511, 0, 201, 221);
    send(32'd1, 1, 511, 0, 0, -1);
    send(32'd1 << 25, 1, 511, 0, 301, -1);
    send(32'd0, 1, 511, 0, 0, -1);
    send(32'h3FFFFFF, 2, 511, 0, -1, -1);

    // Hysteresis with k=0 so the average follows the sample directly.
    do_reset();
    send(32'd55296, 0, 200, 180, 190, 190);
    send(32'd131072, 0, 200, 180, 205, 205);
    send(32'd55296, 0, 200, 180, 190, 190);
    send(32'd23552, 0, 200, 180, 175, 175);
    // Inverted band: the high threshold takes priority.
    send(32'd23552, 0, 100, 250, 175, 175);
    send(32'd1, 0, 100, 250, 0, 0);

    for (int i = 0; i < 40; i++) begin
      p = ($urandom & 32'h3FFFFFF) >> $urandom_range(0, 25);
      if (i % 13 == 5) p = 0;
      send(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 320)),
           int'($urandom_range(0, 320)), -1, -1);
    end

    chk("overrun_before", int'(overrun), 0);
    // A second strobe two cycles in is dropped and flagged.
    issue(32'd1, 1, 511, 0, 0, -1);
    @(negedge clk);
    pow = 26'd12345;
    pow_vld = 1'b1;
    @(negedge clk);
    pow_vld = 1'b0;
    wait_vld();
    @(negedge clk);
    chk("overrun_after", int'(overrun), 1);
    repeat (40) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset during NORM abandons the conversion.
    issue(32'd1, 1, 511, 0, -1, -1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    check_all_zero("after_mid_reset");

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
